booth_mul: RTL and testbench

BOOTH_MUL -- requirements
Module: booth_mul

---
 rtl/booth_mul.sv | 102 ++++++++++
 tb/tb_booth_mul.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier for signed WIDTH-bit operands; one iteration per clock.
// Optional macro BOOTH_MUL_ZERO_SKIP_EN: zero operands finish in a single cycle.
module booth_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]       state;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic             q_m1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             zero_op;

`ifdef BOOTH_MUL_ZERO_SKIP_EN
  assign zero_op = (multiplicand == {WIDTH{1'b0}}) || (multiplier == {WIDTH{1'b0}});
`else
  assign zero_op = 1'b0;
`endif

  // Booth add/subtract in WIDTH+1 bits, then arithmetic shift of {acc, mplier, q_m1}
  always_comb begin
    sum = acc;
    case ({mplier[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_next    = {sum[WIDTH], sum[WIDTH:1]};
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= {(2*WIDTH){1'b0}};
      acc     <= {(WIDTH+1){1'b0}};
      mcand   <= {(WIDTH+1){1'b0}};
      mplier  <= {WIDTH{1'b0}};
      q_m1    <= 1'b0;
      count   <= {CW{1'b0}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            acc   <= {(WIDTH+1){1'b0}};
            q_m1  <= 1'b0;
            // A zero operand runs one all-zero iteration so the product comes out as 0
            if (zero_op) begin
              mcand  <= {(WIDTH+1){1'b0}};
              mplier <= {WIDTH{1'b0}};
              count  <= CW'(1);
            end else begin
              mcand  <= {multiplicand[WIDTH-1], multiplicand};
              mplier <= multiplier;
              count  <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          q_m1   <= mplier[0];
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {acc_next[WIDTH-1:0], mplier_next};
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// Directed self-checking bench for booth_mul at WIDTH=8 with hand-computed products.
// Honours BOOTH_MUL_ZERO_SKIP_EN for the zero-operand latency.
module tb_booth_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks = 0;
  int n_errors = 0;

  booth_mul #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

`ifdef BOOTH_MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 8;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at #1 after the accepting edge; returns edges until done and cycles busy was seen
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic launch(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp, input int exp_lat);
    int lat, bc;
    launch(m, q);
    check({tag, "_busy_after_start"}, busy, 1);
    wait_done(lat, bc);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_product"}, product, exp);
    check({tag, "_busy_in_done"}, busy, 0);
  endtask

  initial begin
    int lat, bc, pulses;
    rst = 1'b1;
    start = 1'b0;
    multiplicand = 8'h00;
    multiplier = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic product, latency, busy length and one-cycle done
    launch(8'd3, 8'd5);
    wait_done(lat, bc);
    check("m3q5_latency", lat, 8);
    check("m3q5_busy_cycles", bc, 8);
    check("m3q5_product", product, 16'h000F);
    @(posedge clk); #1;
    check("m3q5_done_one_cycle", done, 0);
    check("m3q5_product_held", product, 16'h000F);

    run_mul("m_neg3_q5", 8'hFD, 8'd5, 16'hFFF1, 8);
    run_mul("min_x_min", 8'h80, 8'h80, 16'h4000, 8);
    run_mul("min_x_max", 8'h80, 8'h7F, 16'hC080, 8);
    run_mul("max_x_max", 8'h7F, 8'h7F, 16'h3F01, 8);
    run_mul("max_x_neg1", 8'h7F, 8'hFF, 16'hFF81, 8);

    // Start and operand changes while busy are ignored
    launch(8'd7, 8'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    multiplicand = 8'd1;
    multiplier = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("ignored_start_latency", lat + 3, 8);
    check("ignored_start_product", product, 16'h003F);

    // Reset mid-calculation, with start asserted at the reset edge
    launch(8'd7, 8'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    multiplicand = 8'd3;
    multiplier = 8'd5;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("midrst_no_activity", pulses, 0);
    run_mul("after_rst", 8'd2, 8'hFE, 16'hFFFC, 8);

    // Back-to-back: new start accepted in the done cycle
    launch(8'd3, 8'd5);
    wait_done(lat, bc);
    check("b2b_first_product", product, 16'h000F);
    start = 1'b1;
    multiplicand = 8'hFF;
    multiplier = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accepted_busy", busy, 1);
    check("b2b_accepted_done", done, 0);
    wait_done(lat, bc);
    check("b2b_latency", lat, 8);
    check("b2b_product", product, 16'h0001);

    // Zero operands
    run_mul("zero_m", 8'h00, 8'd55, 16'h0000, ZERO_LAT);
    run_mul("nonzero_after_zero", 8'd6, 8'd7, 16'h002A, 8);
    run_mul("zero_q", 8'hFB, 8'h00, 16'h0000, ZERO_LAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
